// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter slice.
// Entry layout and source encoding used by the arbiter and its result FIFO.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADR_W  = 5;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_EXT
    } wb_src_e;

    typedef struct packed {
        logic [WB_ADR_W-1:0]  adr;
        logic [WB_DATA_W-1:0] value;
    } wb_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO for multi-cycle writeback entries.
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage is not reset; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and multi-cycle results onto the register bank write port.
// Optional WB_PERF_EN adds saturating write/stall performance counters.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADR_W        = WB_ADR_W,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADR_W-1:0]    alu_adr,
    input  logic [DATA_W-1:0]   alu_value,
    output logic                alu_stall,
    input  logic                ext_valid,
    output logic                ext_ready,
    input  logic [ADR_W-1:0]    ext_adr,
    input  logic [DATA_W-1:0]   ext_value,
    input  logic                iss_valid,
    input  logic [ADR_W-1:0]    iss_adr,
    output logic [2**ADR_W-1:0] pending,
    output logic [ADR_W-1:0]    wadr,
    output logic [DATA_W-1:0]   wvalue,
    output logic                wenable
`ifdef WB_PERF_EN
    ,
    output logic [31:0]         perf_alu_wr,
    output logic [31:0]         perf_ext_wr,
    output logic [31:0]         perf_stall
`endif
);

    localparam int NREG = 2**ADR_W;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);

    wb_entry_t       ext_in;
    wb_entry_t       head;
    logic            full;
    logic            empty;
    logic            pop;
    wb_src_e         sel;
    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_nxt;
    logic            stall_nxt;
    logic [NREG-1:0] pending_nxt;

    assign ext_in    = '{adr: ext_adr, value: ext_value};
    assign ext_ready = !full;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (ext_valid),
        .din   (ext_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // ALU has priority unless the starvation stall is active.
    always_comb begin
        sel = WB_SRC_NONE;
        if (alu_valid && !alu_stall) begin
            sel = WB_SRC_ALU;
        end else if (!empty) begin
            sel = WB_SRC_EXT;
        end
    end

    assign pop = (sel == WB_SRC_EXT);

    always_comb begin
        starve_nxt = starve_cnt;
        stall_nxt  = 1'b0;
        if (pop || empty) begin
            starve_nxt = '0;
        end else if (sel == WB_SRC_ALU) begin
            starve_nxt = starve_cnt + 1'b1;
            stall_nxt  = (starve_cnt == CW'(STARVE_LIMIT - 1));
        end
    end

    // Clear before set so a same-cycle issue to the committed register wins.
    always_comb begin
        pending_nxt = pending;
        if (pop) begin
            pending_nxt[head.adr] = 1'b0;
        end
        if (iss_valid && (iss_adr != '0)) begin
            pending_nxt[iss_adr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_stall  <= 1'b0;
            starve_cnt <= '0;
            pending    <= '0;
            wadr       <= '0;
            wvalue     <= '0;
            wenable    <= 1'b0;
        end else begin
            alu_stall  <= stall_nxt;
            starve_cnt <= starve_nxt;
            pending    <= pending_nxt;
            unique case (sel)
                WB_SRC_ALU: begin
                    wadr    <= alu_adr;
                    wvalue  <= alu_value;
                    wenable <= (alu_adr != '0);
                end
                WB_SRC_EXT: begin
                    wadr    <= head.adr;
                    wvalue  <= head.value;
                    wenable <= (head.adr != '0);
                end
                default: begin
                    wenable <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_alu_wr <= '0;
            perf_ext_wr <= '0;
            perf_stall  <= '0;
        end else begin
            if (sel == WB_SRC_ALU) perf_alu_wr <= sat_inc(perf_alu_wr);
            if (sel == WB_SRC_EXT) perf_ext_wr <= sat_inc(perf_ext_wr);
            if (alu_stall)         perf_stall  <= sat_inc(perf_stall);
        end
    end
`endif

endmodule
